// File: rtl/video_pkg.sv
// video_pkg: 640x480@60 timing, colour and pattern-select constants for the pixel domain
package video_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP = 33;
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam logic [23:0] COL_WHITE = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED = 24'hFF0000;
  localparam logic [23:0] COL_BLUE = 24'h0000FF;
  localparam logic [23:0] COL_BLACK = 24'h000000;
  localparam logic [23:0] BAR_COLOURS [8] = '{COL_WHITE, COL_YELLOW, COL_CYAN, COL_GREEN,
                                               COL_MAGENTA, COL_RED, COL_BLUE, COL_BLACK};
  typedef enum logic [1:0] {PAT_BARS, PAT_CHECKER, PAT_GRADIENT, PAT_RED} pat_e;
endpackage

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: combinational test-pattern colour for the current pixel
module video_pattern_gen
  import video_pkg::*;
(
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [2:0]  bar_idx,
  input  pat_e        sel,
  output logic [23:0] rgb
);
  logic [7:0] grad_b;
  assign grad_b = 8'((11'(h_cnt) + 11'(v_cnt)) >> 1);
  always_comb
    rgb = sel == PAT_BARS     ? BAR_COLOURS[bar_idx] :
          sel == PAT_CHECKER  ? {24{h_cnt[5] ^ v_cnt[5]}} :
          sel == PAT_GRADIENT ? {h_cnt[7:0], v_cnt[7:0], grad_b} : COL_RED;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel counters, sync/de timing and registered test-pattern output
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP = VGA_V_BP,
  parameter int H_POL = 0,
  parameter int V_POL = 0
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        line_start,
  output logic [23:0] rgb
);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);
  localparam logic HP = 1'(H_POL);
  localparam logic VP = 1'(V_POL);
  logic [9:0] h_cnt, v_cnt, bar_px;
  logic [2:0] bar_idx;
  logic h_wrap, v_wrap, at_origin, bar_end, act;
  pat_e sel_q, sel_eff;
  logic [23:0] pix;
  assign h_wrap = h_cnt == H_LAST;
  assign v_wrap = v_cnt == V_LAST;
  assign at_origin = h_cnt == '0 && v_cnt == '0;
  assign bar_end = bar_px == BAR_LAST;
  assign act = h_cnt < H_ACT && v_cnt < V_ACT;
  // The whole frame, including pixel (0,0), uses the selection sampled at the origin
  assign sel_eff = at_origin ? pat_e'(pattern_sel) : sel_q;
  video_pattern_gen u_pattern (
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .bar_idx(bar_idx),
    .sel    (sel_eff),
    .rgb    (pix)
  );
  always_ff @(posedge clk_25)
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      bar_px <= '0;
      bar_idx <= '0;
      sel_q <= PAT_BARS;
      hsync <= ~HP;
      vsync <= ~VP;
      de <= 1'b0;
      x <= '0;
      y <= '0;
      frame_start <= 1'b0;
      line_start <= 1'b0;
      rgb <= '0;
    end else if (en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      v_cnt <= h_wrap ? (v_wrap ? '0 : v_cnt + 10'd1) : v_cnt;
      bar_px <= h_wrap || bar_end ? '0 : bar_px + 10'd1;
      bar_idx <= h_wrap ? '0 : bar_idx + {2'b0, bar_end};
      sel_q <= sel_eff;
      hsync <= h_cnt >= HS_START && h_cnt < HS_END ? HP : ~HP;
      vsync <= v_cnt >= VS_START && v_cnt < VS_END ? VP : ~VP;
      de <= act;
      x <= h_cnt;
      y <= v_cnt;
      frame_start <= at_origin;
      line_start <= h_cnt == '0 && v_cnt < V_ACT;
      rgb <= act ? pix : '0;
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: reduced-geometry timing generator bench with a per-cycle reference model
module tb_video_timing_gen;
  localparam int HA = 80, HFP = 4, HS = 8, HBP = 8;
  localparam int VA = 70, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int BW = HA / 8;
  logic clk_25 = 1'b0, rst = 1'b1, en = 1'b1;
  logic [1:0] pattern_sel = 2'd0;
  logic hsync, vsync, de, frame_start, line_start;
  logic [9:0] x, y;
  logic [23:0] rgb;
  int total = 0, bad = 0;
  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(0), .V_POL(0)
  ) dut (
    .clk_25(clk_25), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start), .rgb(rgb)
  );
  always #5 clk_25 = ~clk_25;
  function automatic logic [23:0] bar_colour(int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
  function automatic logic [23:0] colour(int h, int v, logic [1:0] s);
    if (h >= HA || v >= VA) return 24'h0;
    case (s)
      2'd0: return bar_colour(h / BW);
      2'd1: return ((h / 32 + v / 32) % 2) == 1 ? 24'hFFFFFF : 24'h000000;
      2'd2: return {8'(h % 256), 8'(v % 256), 8'(((h + v) / 2) % 256)};
      default: return 24'hFF0000;
    endcase
  endfunction
  int mh = 0, mv = 0, e_x = 0, e_y = 0;
  logic [1:0] msel = 2'd0;
  logic e_hs = 1'b1, e_vs = 1'b1, e_de = 1'b0, e_fs = 1'b0, e_ls = 1'b0;
  logic [23:0] e_rgb = 24'h0;
  always @(posedge clk_25)
    if (rst) begin
      mh <= 0; mv <= 0; msel <= 2'd0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0; e_fs <= 1'b0; e_ls <= 1'b0;
      e_x <= 0; e_y <= 0; e_rgb <= 24'h0;
    end else if (en) begin
      e_hs <= !(mh >= HA + HFP && mh < HA + HFP + HS);
      e_vs <= !(mv >= VA + VFP && mv < VA + VFP + VS);
      e_de <= mh < HA && mv < VA;
      e_fs <= mh == 0 && mv == 0;
      e_ls <= mh == 0 && mv < VA;
      e_x <= mh;
      e_y <= mv;
      e_rgb <= colour(mh, mv, (mh == 0 && mv == 0) ? pattern_sel : msel);
      msel <= (mh == 0 && mv == 0) ? pattern_sel : msel;
      mh <= (mh + 1) % HT;
      mv <= mh == HT - 1 ? (mv + 1) % VT : mv;
    end
  always @(negedge clk_25) begin
    total++;
    if ({hsync, vsync, de, frame_start, line_start, x, y, rgb} !==
        {e_hs, e_vs, e_de, e_fs, e_ls, 10'(e_x), 10'(e_y), e_rgb}) begin
      bad++;
      $display("FAIL model t=%0t got hs=%b vs=%b de=%b fs=%b ls=%b x=%0d y=%0d rgb=%h want hs=%b vs=%b de=%b fs=%b ls=%b x=%0d y=%0d rgb=%h",
               $time, hsync, vsync, de, frame_start, line_start, x, y, rgb,
               e_hs, e_vs, e_de, e_fs, e_ls, e_x, e_y, e_rgb);
    end
  end
  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  task automatic wait_xy(int tx, int ty);
    int n = 0;
    do begin
      @(negedge clk_25);
      n++;
    end while (!(int'(x) == tx && int'(y) == ty) && n < 20000);
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL wait_xy timeout at (%0d,%0d) got x=%0d y=%0d", tx, ty, x, y);
    end
  endtask
  initial begin
    int n_de, n_hs, n_vs, n_ls, hs_x, vs_y;
    repeat (5) @(negedge clk_25);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_de", int'(de), 0);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_xy", int'({x, y}), 0);
    rst = 1'b0;
    @(negedge clk_25);
    chk("start_de", int'(de), 1);
    chk("start_fs", int'(frame_start), 1);
    chk("start_ls", int'(line_start), 1);
    chk("start_rgb", int'(rgb), 24'hFFFFFF);
    n_de = 0; n_hs = 0; n_vs = 0; n_ls = 0; hs_x = -1; vs_y = -1;
    for (int i = 0; i < HT * VT; i++) begin
      n_de += int'(de);
      n_ls += int'(line_start);
      if (!hsync) n_hs++;
      if (!vsync) n_vs++;
      if (!hsync && hs_x < 0) hs_x = int'(x);
      if (!vsync && vs_y < 0) vs_y = int'(y);
      @(negedge clk_25);
    end
    chk("frame_len_fs", int'(frame_start), 1);
    chk("frame_len_xy", int'({x, y}), 0);
    chk("de_count", n_de, 5600);
    chk("ls_count", n_ls, 70);
    chk("hsync_low", n_hs, 616);
    chk("hsync_start_x", hs_x, 84);
    chk("vsync_low", n_vs, 200);
    chk("vsync_start_y", vs_y, 72);
    wait_xy(9, 5);  chk("bar_x9", int'(rgb), 24'hFFFFFF);
    wait_xy(10, 5); chk("bar_x10", int'(rgb), 24'hFFFF00);
    wait_xy(69, 5); chk("bar_x69", int'(rgb), 24'h0000FF);
    wait_xy(70, 5); chk("bar_x70", int'(rgb), 24'h000000);
    wait_xy(79, 5); chk("bar_x79", int'(rgb), 24'h000000);
    wait_xy(80, 5); chk("blank_de", int'(de), 0);
    wait_xy(40, 35);
    pattern_sel = 2'd1;
    wait_xy(5, 50); chk("defer_same_frame", int'(rgb), 24'hFFFFFF);
    wait_xy(0, 0);  chk("defer_origin", int'(rgb), 24'h000000);
    wait_xy(32, 0); chk("chk_32_0", int'(rgb), 24'hFFFFFF);
    wait_xy(32, 32); chk("chk_32_32", int'(rgb), 24'h000000);
    wait_xy(30, 40);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_25);
      chk("stall_x", int'(x), 30);
      chk("stall_rgb", int'(rgb), 24'hFFFFFF);
    end
    en = 1'b1;
    @(negedge clk_25);
    chk("resume_x", int'(x), 31);
    chk("resume_y", int'(y), 40);
    pattern_sel = 2'd2;
    wait_xy(0, 0);
    wait_xy(40, 30); chk("grad_40_30", int'(rgb), 24'h281E23);
    rst = 1'b1;
    @(negedge clk_25);
    chk("mid_rst_hsync", int'(hsync), 1);
    chk("mid_rst_de", int'(de), 0);
    chk("mid_rst_rgb", int'(rgb), 0);
    chk("mid_rst_xy", int'({x, y}), 0);
    repeat (2) @(negedge clk_25);
    pattern_sel = 2'd0;
    rst = 1'b0;
    @(negedge clk_25);
    chk("restart_fs", int'(frame_start), 1);
    chk("restart_rgb", int'(rgb), 24'hFFFFFF);
    wait_xy(20, 0); chk("restart_bar2", int'(rgb), 24'h00FFFF);
    pattern_sel = 2'd3;
    wait_xy(0, 0);
    wait_xy(50, 10); chk("solid_red", int'(rgb), 24'hFF0000);
    repeat (5) @(negedge clk_25);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
